lsu_mem_adapter: RTL
====================

# lsu_mem_adapter

- Load/store adapter for the RV32I pipelined core's memory-access stage; sits directly upstream of the word-only data memory.
- Turns byte-addressed LB/LH/LW/LBU/LHU and SB/SH/SW requests into 1-cycle-latency word reads and writes.
- Sub-word stores use a read-modify-write sequence; loads are extracted and sign/zero-extended.
- Misaligned or illegal accesses are flagged instead of touching memory, and the pipeline is stalled while an access is in flight.

## Interface
- ADDR_W, 10, word-address width driven to the data memory.
- clk  input  1  clock; all state updates on rising edge.
- r  input  1  reset, asynchronous, active-high.
- req_valid  input  1  memory-stage request present; held stable while stall=1.
- req_write  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I load/store funct3.
- addr  input  32  byte address.
- wdata  input  32  store data (low byte/half used for SB/SH).
- stall  output  1  hold pipeline; combinational.
- resp_valid  output  1  one-cycle completion pulse; registered.
- load_data  output  32  extended load result, valid with resp_valid; registered.
- misaligned  output  1  access rejected, valid with resp_valid; registered.
- mem_address  output  ADDR_W  word address = addr[ADDR_W+1:2]; combinational.
- mem_read_en  output  1  read command to memory; combinational.
- mem_write_en  output  1  write command to memory; combinational.
- mem_write_data  output  32  write word; combinational.
- mem_read_data  input  32  memory read word, valid the cycle after mem_read_en.

## Operation
- States: IDLE, LD_WAIT, RMW, RESP.
- IDLE, req_valid=0: no memory command, stall=0.
- IDLE, request illegal:
  - Illegal means: load funct3 ∉ {000,001,010,100,101}; store funct3 ∉ {000,001,010}; halfword with addr[0]=1; word with addr[1:0]≠0.
  - Response: no memory command, stall=1, go to RESP with misaligned=1 and load_data=0.
- IDLE, legal load: mem_read_en=1, stall=1; latch funct3 and addr[1:0]; go to LD_WAIT.
- LD_WAIT:
  - Extract from mem_read_data. LB/LBU take byte lane addr[1:0]; LH/LHU take half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into load_data; stall=1; go to RESP.
- IDLE, SW: mem_write_en=1, mem_write_data=wdata, stall=1; go to RESP.
- IDLE, SB/SH: mem_read_en=1, stall=1; latch word address, lane, funct3 and wdata; go to RMW.
- RMW:
  - Merge wdata[7:0] (SB) or wdata[15:0] (SH) into the addressed lane of mem_read_data.
  - Drive mem_write_en=1 with the merged word on the latched address; stall=1; go to RESP.
- RESP: resp_valid=1, stall=0; pipeline advances on this edge; go to IDLE.
- mem_read_en and mem_write_en are never high together. mem_address is the latched address in LD_WAIT and RMW.
- addr[31:ADDR_W+2] is ignored (address wraps modulo 4·2^ADDR_W bytes).
- Reset values: state IDLE; resp_valid=0, load_data=0, misaligned=0; latched registers 0. All combinational outputs are therefore 0.
- Reset mid-operation: the access is abandoned immediately. An in-progress RMW write is never issued and memory is unchanged.

## Timing
- Request accepted in cycle T (state IDLE, req_valid=1).
- Loads: read in T, capture in T+1, resp_valid in T+2 → 3 cycles, stall high in T and T+1.
- SW: write in T, resp_valid in T+1 → 2 cycles.
- SB/SH: read in T, merged write in T+1, resp_valid in T+2 → 3 cycles.
- Illegal access: resp_valid in T+1.
- A new request may be accepted in the cycle after RESP. No overlap between requests.

## Structure
- Package rv32i_mem_pkg holds:
  - funct3 constants (F3_B/H/W/BU/HU);
  - the state encoding;
  - the lane-extract and lane-merge functions.
- Sub-module lsu_align (combinational): byte/half extract with sign/zero extension, plus store-lane merge. Instantiated once for each path.

## Test plan
- SW 0x8081_82F3 @0x10 → mem_write_en high one cycle. Then:
  - LB @0x10 → 0xFFFF_FFF3
  - LBU @0x13 → 0x0000_0080
  - LH @0x12 → 0xFFFF_8081
  - LHU @0x10 → 0x0000_82F3
- SB 0xAA @0x11 → read at T, single write at T+1; LW @0x10 → 0x8081_AAF3.
- SH 0x1234 @0x12 → LW @0x10 → 0x1234_AAF3; bytes outside the lane unchanged.
- Illegal accesses: LW @0x02, SH @0x11 and load funct3=011 → resp_valid at T+1, misaligned=1, load_data=0, no mem_read_en/mem_write_en.
- Assert r during the RMW cycle of SB 0x55 @0x10 → mem_write_en drops immediately; LW @0x10 afterwards → 0x1234_AAF3; all registered outputs 0.
- Back-to-back SW, LW, SB, LW → stall high 1, 2, 2, 2 cycles respectively; resp_valid pulses exactly once per request.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg
// Shared definitions for the RV32I memory-access stage:
//   - funct3 encodings for loads/stores (F3_B/H/W/BU/HU)
//   - adapter FSM state encoding
//   - legality check, load lane-extract and store lane-merge helpers
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        RMW     = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    // True when the access may touch memory: known funct3 for its
    // direction and natural alignment for halfwords and words.
    function automatic logic access_legal(input logic       write,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:  ok = 1'b1;
            F3_H:  ok = (off[0] == 1'b0);
            F3_W:  ok = (off == 2'b00);
            F3_BU: ok = !write;
            F3_HU: ok = !write && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_BU:   res = {24'h0, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_HU:   res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of a memory word with store data.
    // Word stores return the store data unchanged.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
        logic [31:0] m;
        m = word;
        case (f3)
            F3_B: m[{lane, 3'b000} +: 8] = data[7:0];
            F3_H: begin
                if (lane[1]) m[31:16] = data[15:0];
                else         m[15:0]  = data[15:0];
            end
            default: m = data;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Combinational lane logic. MERGE=0 extracts and extends a load lane from
// mem_word; MERGE=1 merges store_data into the addressed lane of mem_word.
// Ports:
//   mem_word    in  32  word read from memory
//   store_data  in  32  store data (low byte/half used for sub-word)
//   f3          in  3   funct3 of the access
//   lane        in  2   byte offset addr[1:0]
//   result      out 32  extended load value or merged store word
module lsu_align
    import rv32i_mem_pkg::*;
#(
    parameter bit MERGE = 1'b0
) (
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    input  logic [2:0]  f3,
    input  logic [1:0]  lane,
    output logic [31:0] result
);

    logic [31:0] extracted;
    logic [31:0] merged;

    assign extracted = lane_extract(mem_word, f3, lane);
    assign merged    = lane_merge(mem_word, store_data, f3, lane);
    assign result    = MERGE ? merged : extracted;

endmodule

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter
// Load/store adapter between the memory-access stage and a word-only data
// memory with 1-cycle read latency. Sub-word stores are done as a
// read-modify-write; illegal/misaligned accesses never reach memory.
// Ports:
//   clk, r                 clock, async active-high reset
//   req_valid/req_write    request present / store(1) or load(0)
//   funct3, addr, wdata    RV32I funct3, byte address, store data
//   stall                  hold pipeline (combinational)
//   resp_valid             one-cycle completion pulse (registered)
//   load_data, misaligned  result and rejection flag with resp_valid
//   mem_address/_read_en/_write_en/_write_data  memory command (comb)
//   mem_read_data          memory word, valid the cycle after a read
module lsu_mem_adapter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              r,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_t        state;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              legal;
    logic [31:0]       load_ext;
    logic [31:0]       store_merged;

    // High address bits are intentionally dropped: accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign legal = access_legal(req_write, funct3, addr[1:0]);

    lsu_align #(.MERGE(1'b0)) u_load_align (
        .mem_word   (mem_read_data),
        .store_data (32'h0),
        .f3         (f3_q),
        .lane       (lane_q),
        .result     (load_ext)
    );

    lsu_align #(.MERGE(1'b1)) u_store_align (
        .mem_word   (mem_read_data),
        .store_data (wdata_q),
        .f3         (f3_q),
        .lane       (lane_q),
        .result     (store_merged)
    );

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state      <= IDLE;
            f3_q       <= 3'b0;
            lane_q     <= 2'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            resp_valid <= 1'b0;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            misaligned <= 1'b1;
                            load_data  <= 32'h0;
                        end else begin
                            f3_q       <= funct3;
                            lane_q     <= addr[1:0];
                            addr_q     <= addr[ADDR_W+1:2];
                            wdata_q    <= wdata;
                            misaligned <= 1'b0;
                            load_data  <= 32'h0;
                            if (!req_write) begin
                                state <= LD_WAIT;
                            end else if (funct3 == F3_W) begin
                                state      <= RESP;
                                resp_valid <= 1'b1;
                            end else begin
                                state <= RMW;
                            end
                        end
                    end
                end
                LD_WAIT: begin
                    load_data  <= load_ext;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RMW: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory command decode. Reset forces everything quiet so an RMW write
    // in flight is dropped the moment reset asserts.
    always_comb begin
        stall          = 1'b0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_write_data = 32'h0;
        mem_address    = addr_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stall       = 1'b1;
                    mem_address = addr[ADDR_W+1:2];
                    if (legal) begin
                        if (req_write && funct3 == F3_W) begin
                            mem_write_en   = 1'b1;
                            mem_write_data = wdata;
                        end else begin
                            // loads and the read half of SB/SH
                            mem_read_en = 1'b1;
                        end
                    end
                end
            end
            LD_WAIT: stall = 1'b1;
            RMW: begin
                stall          = 1'b1;
                mem_write_en   = 1'b1;
                mem_write_data = store_merged;
            end
            default: ;
        endcase
        if (r) begin
            stall          = 1'b0;
            mem_read_en    = 1'b0;
            mem_write_en   = 1'b0;
            mem_write_data = 32'h0;
            mem_address    = '0;
        end
    end

endmodule
